// File: rtl/instr_fetch_unit.sv
// Instruction fetch for the single-cycle MIPS datapath.
// Holds the PC, the preloadable instruction memory and the LOAD/RUN/HALT control.
module instr_fetch_unit #(
    parameter int          ADDR_WIDTH = 6,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data,
    input  logic                  Jump,
    input  logic                  Branch,
    input  logic                  Zero,
    output logic [31:0]           PC,
    output logic [31:0]           PC_plus4,
    output logic [31:0]           Instr,
    output logic [5:0]            Opcode,
    output logic [4:0]            rs,
    output logic [4:0]            rt,
    output logic [4:0]            rd,
    output logic [4:0]            shamt,
    output logic [5:0]            funct,
    output logic [15:0]           imm,
    output logic                  running,
    output logic                  halted,
    output logic                  fault,
    output logic [31:0]           instr_count
);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam int         DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [5:0] OP_HALT = 6'b111111;

    logic [1:0]            state;
    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] ridx;
    logic                  in_range;
    logic [31:0]           br_off;
    logic [31:0]           next_pc;
    logic                  is_halt;

    assign ridx     = PC[ADDR_WIDTH+1:2];
    assign in_range = (PC[31:ADDR_WIDTH+2] == '0);
    assign PC_plus4 = PC + 32'd4;

    // Fetch is gated so that idle/faulted states present a nop.
    assign Instr = (state == S_RUN && in_range) ? mem[ridx] : 32'h0;

    assign Opcode = Instr[31:26];
    assign rs     = Instr[25:21];
    assign rt     = Instr[20:16];
    assign rd     = Instr[15:11];
    assign shamt  = Instr[10:6];
    assign funct  = Instr[5:0];
    assign imm    = Instr[15:0];

    assign running = (state == S_RUN);
    assign halted  = (state == S_HALT);
    assign is_halt = (Opcode == OP_HALT);
    assign br_off  = {{14{Instr[15]}}, Instr[15:0], 2'b00};

    always_comb begin
        next_pc = PC_plus4;
        if (Jump)
            next_pc = {PC_plus4[31:28], Instr[25:0], 2'b00};
        else if (Branch && Zero)
            next_pc = PC_plus4 + br_off;
    end

    // Memory is deliberately left out of reset so a program survives it.
    always_ff @(posedge clk) begin
        if (!reset && state == S_LOAD && load_en)
            mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_LOAD;
            PC          <= RESET_PC;
            instr_count <= 32'h0;
            fault       <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (start)
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (!in_range) begin
                        state <= S_HALT;
                        fault <= 1'b1;
                    end else if (!stall) begin
                        instr_count <= instr_count + 32'd1;
                        if (is_halt)
                            state <= S_HALT;
                        else
                            PC <= next_pc;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table
// for the RUN sequence plus hand-written reset/fault sequences.
module tb_instr_fetch_unit;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset, start, stall, load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          Jump, Branch, Zero;
    logic [31:0]   PC, PC_plus4, Instr, instr_count;
    logic [5:0]    Opcode, funct;
    logic [4:0]    rs, rt, rd, shamt;
    logic [15:0]   imm;
    logic          running, halted, fault;

    int passed = 0;
    int total  = 0;

    instr_fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .Jump(Jump), .Branch(Branch), .Zero(Zero),
        .PC(PC), .PC_plus4(PC_plus4), .Instr(Instr),
        .Opcode(Opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm),
        .running(running), .halted(halted), .fault(fault),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        jump;
        logic        branch;
        logic        zero;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
        logic        run;
        logic        hlt;
        logic        flt;
    } vec_t;

    localparam logic        F   = 1'b0;
    localparam logic        T   = 1'b1;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] BEQ = 32'h1000_FFFE;
    localparam logic [31:0] JMP = 32'h0800_0003;
    localparam logic [31:0] HLT = 32'hFC00_0000;
    localparam logic [31:0] JFR = 32'h0800_0040;

    vec_t tv [17];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            passed++;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        else
            passed++;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stall = 0; load_en = 0; load_addr = '0;
        load_data = '0; Jump = 0; Branch = 0; Zero = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d);
        load_en = 1; load_addr = a; load_data = d;
        step();
        load_en = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        step();
        start = 0;
    endtask

    initial begin
        logic [31:0] e;
        tv[0]  = '{F, F, F, F, 32'h00, NOP, 32'd0,  T, F, F};
        tv[1]  = '{T, F, F, F, 32'h04, NOP, 32'd1,  T, F, F};
        tv[2]  = '{T, F, F, F, 32'h04, NOP, 32'd1,  T, F, F};
        tv[3]  = '{T, F, F, F, 32'h04, NOP, 32'd1,  T, F, F};
        tv[4]  = '{F, F, F, F, 32'h04, NOP, 32'd1,  T, F, F};
        tv[5]  = '{F, F, T, T, 32'h08, BEQ, 32'd2,  T, F, F};
        tv[6]  = '{F, F, F, F, 32'h04, NOP, 32'd3,  T, F, F};
        tv[7]  = '{F, F, T, F, 32'h08, BEQ, 32'd4,  T, F, F};
        tv[8]  = '{F, F, F, F, 32'h0C, NOP, 32'd5,  T, F, F};
        tv[9]  = '{T, T, T, T, 32'h10, JMP, 32'd6,  T, F, F};
        tv[10] = '{F, T, T, T, 32'h10, JMP, 32'd6,  T, F, F};
        tv[11] = '{F, F, F, F, 32'h0C, NOP, 32'd7,  T, F, F};
        tv[12] = '{F, F, F, F, 32'h10, JMP, 32'd8,  T, F, F};
        tv[13] = '{T, F, F, F, 32'h14, HLT, 32'd9,  T, F, F};
        tv[14] = '{F, F, F, F, 32'h14, HLT, 32'd9,  T, F, F};
        tv[15] = '{F, T, T, T, 32'h14, NOP, 32'd10, F, T, F};
        tv[16] = '{F, F, F, F, 32'h14, NOP, 32'd10, F, T, F};

        idle_inputs();
        reset = 1;
        step();
        reset = 0;

        chk("rst_pc", PC, 32'h0);
        chk("rst_cnt", instr_count, 32'h0);
        chk("rst_instr", Instr, 32'h0);
        chk1("rst_run", running, 1'b0);
        chk1("rst_hlt", halted, 1'b0);
        chk1("rst_flt", fault, 1'b0);

        // addi followed by halt
        load_word(6'd0, 32'h2001_0005);
        load_word(6'd1, HLT);
        pulse_start();
        chk("p1_pc0", PC, 32'h0);
        chk("p1_i0", Instr, 32'h2001_0005);
        chk("p1_rt0", {27'b0, rt}, 32'h1);
        chk("p1_imm0", {16'b0, imm}, 32'h5);
        step();
        chk("p1_pc1", PC, 32'h4);
        chk("p1_i1", Instr, HLT);
        chk("p1_cnt1", instr_count, 32'd1);
        step();
        chk1("p1_hlt", halted, 1'b1);
        chk("p1_pc2", PC, 32'h4);
        chk("p1_cnt2", instr_count, 32'd2);
        chk1("p1_flt", fault, 1'b0);
        chk("p1_i2", Instr, 32'h0);

        // table program
        do_reset();
        load_word(6'd0, NOP);
        load_word(6'd1, NOP);
        load_word(6'd2, BEQ);
        load_word(6'd3, NOP);
        load_word(6'd4, JMP);
        load_word(6'd5, HLT);
        pulse_start();
        for (int i = 0; i < 17; i++) begin
            stall = tv[i].stall; Jump = tv[i].jump;
            Branch = tv[i].branch; Zero = tv[i].zero;
            e = tv[i].instr;
            chk($sformatf("pc[%0d]", i), PC, tv[i].pc);
            chk($sformatf("pc4[%0d]", i), PC_plus4, tv[i].pc + 32'd4);
            chk($sformatf("instr[%0d]", i), Instr, e);
            chk($sformatf("op[%0d]", i), {26'b0, Opcode}, {26'b0, e[31:26]});
            chk($sformatf("imm[%0d]", i), {16'b0, imm}, {16'b0, e[15:0]});
            chk($sformatf("cnt[%0d]", i), instr_count, tv[i].cnt);
            chk1($sformatf("run[%0d]", i), running, tv[i].run);
            chk1($sformatf("hlt[%0d]", i), halted, tv[i].hlt);
            chk1($sformatf("flt[%0d]", i), fault, tv[i].flt);
            step();
        end
        idle_inputs();

        // reset mid-RUN at PC 0x14; memory must survive
        do_reset();
        pulse_start();
        for (int i = 0; i < 5; i++) step();
        chk("mr_pc", PC, 32'h14);
        chk1("mr_run", running, 1'b1);
        reset = 1;
        step();
        reset = 0;
        chk("mr_rpc", PC, 32'h0);
        chk("mr_rcnt", instr_count, 32'h0);
        chk1("mr_rrun", running, 1'b0);
        chk1("mr_rhlt", halted, 1'b0);
        pulse_start();
        step();
        step();
        chk("mr_pc8", PC, 32'h8);
        chk("mr_mem", Instr, BEQ);

        // out-of-range jump, load ignored in RUN, start+load together
        do_reset();
        load_en = 1; load_addr = 6'd0; load_data = JFR; start = 1;
        step();
        load_en = 0; start = 0;
        chk1("oor_run", running, 1'b1);
        chk("oor_i0", Instr, JFR);
        Jump = 1; load_en = 1; load_addr = 6'd0; load_data = 32'hDEAD_BEEF;
        step();
        Jump = 0; load_en = 0;
        chk("oor_pc", PC, 32'h100);
        chk("oor_instr", Instr, 32'h0);
        chk("oor_cnt", instr_count, 32'd1);
        chk1("oor_run1", running, 1'b1);
        stall = 1;
        step();
        stall = 0;
        chk1("oor_hlt", halted, 1'b1);
        chk1("oor_flt", fault, 1'b1);
        chk("oor_pc2", PC, 32'h100);
        chk("oor_cnt2", instr_count, 32'd1);
        step();
        chk1("oor_flt_sticky", fault, 1'b1);

        // reset out of HALT clears fault; RUN-time write was dropped
        do_reset();
        chk1("hr_flt", fault, 1'b0);
        chk1("hr_hlt", halted, 1'b0);
        pulse_start();
        chk("hr_mem", Instr, JFR);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the main control decoder in the single-cycle MIPS datapath.
- Holds the PC register and a word-addressed instruction memory, with a write port for program preload.
- Each cycle it presents the current instruction and its split fields (Opcode, rs, rt, rd, shamt, funct, imm).
- It computes the next PC from Jump/Branch (main control) and Zero (ALU), and runs a LOAD/RUN/HALT state machine with a retired-instruction counter.

Parameters:
- ADDR_WIDTH, 6, word-address bits of instruction memory (depth 2^ADDR_WIDTH words).
- RESET_PC, 32'h00000000, PC value after reset; must be word aligned.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  LOAD->RUN request (single-cycle pulse)
- stall  input  1  hold PC and counter for this cycle (RUN only)
- load_en  input  1  instruction memory write enable (LOAD only)
- load_addr  input  ADDR_WIDTH  word address for preload
- load_data  input  32  instruction word for preload
- Jump  input  1  from main control
- Branch  input  1  from main control
- Zero  input  1  from ALU
- PC  output  32  current PC (registered)
- PC_plus4  output  32  PC+4 (combinational)
- Instr  output  32  current instruction
- Opcode  output  6  Instr[31:26]
- rs  output  5  Instr[25:21]
- rt  output  5  Instr[20:16]
- rd  output  5  Instr[15:11]
- shamt  output  5  Instr[10:6]
- funct  output  6  Instr[5:0]
- imm  output  16  Instr[15:0]
- running  output  1  state==RUN
- halted  output  1  state==HALT
- fault  output  1  sticky: halt caused by out-of-range PC
- instr_count  output  32  retired instructions

Behaviour:
- Reset (synchronous, active-high):
  - state=LOAD, PC=RESET_PC, instr_count=0, fault=0.
  - Memory contents are not cleared.
  - Reset wins over every other input in the same cycle, including mid-RUN and in HALT.
- Memory read is combinational: word index = PC[ADDR_WIDTH+1:2].
  - In range means PC[31:ADDR_WIDTH+2]==0.
- Instr is the memory word when state==RUN and PC is in range; otherwise 32'h00000000.
  - Field outputs are always slices of Instr.
- LOAD state:
  - load_en=1 writes load_data to mem[load_addr] at the clock edge.
  - PC holds; instr_count holds.
  - start=1 moves to RUN next cycle. load_en and start in the same cycle: the write happens and the state still moves to RUN.
- RUN state, next-PC priority:
  - Jump: {PC_plus4[31:28], Instr[25:0], 2'b00}.
  - else Branch&&Zero: PC_plus4 + {{14{Instr[15]}}, Instr[15:0], 2'b00}, wrapping mod 2^32.
  - else PC_plus4, which wraps 32'hFFFFFFFC -> 0.
- RUN with stall=0:
  - PC <= next PC.
  - instr_count += 1, wrapping at 2^32.
- RUN with stall=1: PC and count hold; Jump/Branch for that cycle are ignored.
- RUN, halt opcode:
  - Opcode==6'b111111 (stall=0) moves to HALT.
  - PC stays at the halt word's address; the halt instruction is counted.
  - With stall=1, the transition waits.
- RUN, out-of-range PC:
  - Moves to HALT with fault=1 at the next edge, regardless of stall.
  - Not counted; PC holds.
- load_en in RUN/HALT is ignored (no write). start outside LOAD is ignored.
- HALT state: PC, count and fault are frozen; Instr=0. Only reset exits HALT.
- Outputs are stable between edges; there are no combinational paths from load_* to Instr.

Test Plan:
- Preload mem[0]=32'h20010005 (addi), mem[1]=32'hFC000000, then start; Jump=Branch=0 -> PC 0 then 4; HALT with PC=4, instr_count=2, fault=0.
- Branch at PC=8 with imm=16'hFFFE, Branch=1, Zero=1 -> next PC=4. Same with Zero=0 -> next PC=12.
- Jump at PC=0x10 with Instr[25:0]=26'h0000003, Jump=1, Branch=1, Zero=1 -> next PC=0xC (jump has priority).
- stall=1 for 3 cycles at PC=4 -> PC stays 4 and count is unchanged; PC resumes to 8 when stall=0.
- ADDR_WIDTH=6, jump to PC=0x100 -> Instr=0 that cycle; next edge gives halted=1, fault=1, PC=0x100.
- reset asserted mid-RUN at PC=0x14 -> next cycle state LOAD, PC=0, count=0; memory still reads the preloaded words after start.
